// File: rtl/dma_window_loader.sv
// dma_window_loader: fetches BLOCK_SIZE consecutive words from main memory,
// packs them into one flat window register and hands the window to the
// convolution datapath over a valid/ready handshake.
module dma_window_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_SIZE = 25
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  output logic                             busy,
  output logic                             mem_enable,
  output logic                             mem_rw,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] window_out,
  output logic                             window_valid,
  input  logic                             window_ready,
  output logic                             done
);

  localparam int CW = $clog2(BLOCK_SIZE + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]            state, state_n;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]         issue_cnt;
  logic [CW-1:0]         cap_cnt;
  logic                  prev_en;   // mem_enable one cycle ago: mem_rdata is live now
  logic                  last_issue;

  assign last_issue = (issue_cnt == CW'(BLOCK_SIZE - 1));

  // Read-only master: the write strobe is never asserted.
  assign mem_rw = 1'b1;

  // The handshake completes in the same cycle ready is seen in HOLD, so done
  // is a decode of the registered state and the live ready input.
  assign done = (state == HOLD) && window_ready;

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start)        state_n = FETCH;
      FETCH:   if (last_issue)   state_n = DRAIN;
      DRAIN:                     state_n = HOLD;
      HOLD:    if (window_ready) state_n = IDLE;
      default:                   state_n = IDLE;
    endcase
  end

  // State, registered status outputs, request issue and word capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      window_valid <= 1'b0;
      mem_enable   <= 1'b0;
      mem_address  <= '0;
      base_q       <= '0;
      issue_cnt    <= '0;
      cap_cnt      <= '0;
      prev_en      <= 1'b0;
      window_out   <= '0;
    end else begin
      state        <= state_n;
      busy         <= (state_n != IDLE);
      window_valid <= (state_n == HOLD);
      mem_enable   <= (state_n == FETCH);
      prev_en      <= mem_enable;

      if (state == IDLE && start) begin
        base_q      <= base_addr;
        mem_address <= base_addr;
        issue_cnt   <= '0;
        cap_cnt     <= '0;
      end else begin
        // Next request address; wraps modulo 2^ADDR_WIDTH naturally.
        if (state == FETCH && !last_issue) begin
          issue_cnt   <= issue_cnt + CW'(1);
          mem_address <= base_q + ADDR_WIDTH'(issue_cnt + CW'(1));
        end
        // Data returned for last cycle's request lands in word cap_cnt.
        if (prev_en && cap_cnt < CW'(BLOCK_SIZE)) begin
          window_out[cap_cnt*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
          cap_cnt <= cap_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_window_loader.sv
// Directed bench for dma_window_loader: basic fetch, backpressure, ignored
// start, address wrap, mid-fetch reset and back-to-back windows.
module tb_dma_window_loader;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int BS = 25;
  localparam int WW = BS * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          busy;
  logic          mem_enable;
  logic          mem_rw;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_rdata;
  logic [WW-1:0] window_out;
  logic          window_valid;
  logic          window_ready;
  logic          done;

  int total = 0;
  int bad   = 0;
  int ndone = 0;

  dma_window_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .busy(busy),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_address(mem_address),
    .mem_rdata(mem_rdata), .window_out(window_out), .window_valid(window_valid),
    .window_ready(window_ready), .done(done)
  );

  always #5 clk = ~clk;

  // Memory model: mem[a] = a ^ 5A5A, read data one cycle after the request.
  always @(posedge clk) begin
    if (mem_enable) mem_rdata <= mem_address ^ 16'h5A5A;
  end

  function automatic logic [WW-1:0] exp_win(input logic [AW-1:0] base);
    logic [WW-1:0] w;
    logic [AW-1:0] a;
    w = '0;
    for (int k = 0; k < BS; k++) begin
      a = base + AW'(k);
      w[k*DW +: DW] = a ^ 16'h5A5A;
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full fetch starting in the current cycle (cycle 0) with ready high at
  // cycle 27; returns at cycle 28 with the block back in IDLE.
  task automatic fetch(input string tag, input logic [AW-1:0] base);
    logic [AW-1:0] a;
    start = 1'b1; base_addr = base;
    step();
    start = 1'b0;
    for (int k = 0; k < BS; k++) begin
      a = base + AW'(k);
      chk({tag, "_en"},   mem_enable, 1);
      chk({tag, "_addr"}, mem_address, a);
      chk({tag, "_vld"},  window_valid, 0);
      chk({tag, "_rw"},   mem_rw, 1);
      if (done) ndone++;
      step();
    end
    chk({tag, "_drain_en"},   mem_enable, 0);
    chk({tag, "_drain_busy"}, busy, 1);
    chk({tag, "_drain_vld"},  window_valid, 0);
    if (done) ndone++;
    step();
    chk({tag, "_hold_vld"}, window_valid, 1);
    chk_win({tag, "_win"}, window_out, exp_win(base));
    window_ready = 1'b1;
    #1;
    chk({tag, "_done"}, done, 1);
    if (done) ndone++;
    step();
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_vld"},  window_valid, 0);
    chk({tag, "_idle_done"}, done, 0);
  endtask

  initial begin
    logic [AW-1:0] a;
    rst = 1'b1; start = 1'b0; base_addr = '0; window_ready = 1'b0;
    step(); step();
    // Reset state.
    chk("rst_busy", busy, 0);
    chk("rst_en", mem_enable, 0);
    chk("rst_rw", mem_rw, 1);
    chk("rst_addr", mem_address, 0);
    chk("rst_vld", window_valid, 0);
    chk("rst_done", done, 0);
    chk_win("rst_win", window_out, '0);
    // rst wins over start.
    start = 1'b1; base_addr = 16'h1234;
    step();
    chk("rst_start_busy", busy, 0);
    chk("rst_start_en", mem_enable, 0);
    rst = 1'b0; start = 1'b0;
    step();

    // Basic fetch.
    fetch("basic", 16'h0010);
    window_ready = 1'b0;
    step();

    // Backpressure: ready low for 10 cycles in HOLD.
    start = 1'b1; base_addr = 16'h0040;
    step();
    start = 1'b0;
    for (int i = 0; i < BS + 1; i++) step();
    for (int i = 0; i < 10; i++) begin
      chk("bp_vld", window_valid, 1);
      chk("bp_done", done, 0);
      chk("bp_en", mem_enable, 0);
      chk_win("bp_win", window_out, exp_win(16'h0040));
      step();
    end
    window_ready = 1'b1;
    #1;
    chk("bp_done_ready", done, 1);
    step();
    window_ready = 1'b0;
    #1;
    chk("bp_after_done", done, 0);
    chk("bp_after_busy", busy, 0);
    step();

    // Ignored start: pulses at cycles 5 and 27 during a fetch from 0.
    window_ready = 1'b1; ndone = 0;
    start = 1'b1; base_addr = 16'h0000;
    step();
    start = 1'b0;
    for (int k = 0; k < BS + 1; k++) begin
      if (k < BS) chk("ign_addr", mem_address, 16'(k));
      if (done) ndone++;
      if (k == 4) begin start = 1'b1; base_addr = 16'h0100; end
      step();
      start = 1'b0;
    end
    // Cycle 27: handshake; start here must be ignored.
    start = 1'b1; base_addr = 16'h0100;
    #1;
    chk("ign_done", done, 1);
    if (done) ndone++;
    step();
    start = 1'b0;
    chk("ign_one_done", ndone, 1);
    chk("ign_idle_busy", busy, 0);
    // Start on the cycle after done begins a fetch from 0x0100.
    fetch("ign_new", 16'h0100);
    window_ready = 1'b0;
    step();

    // Address wrap.
    fetch("wrap", 16'hFFF0);
    window_ready = 1'b0;
    chk("wrap_word16", window_out[16*DW +: DW], 16'h5A5A);
    step();

    // Reset mid-fetch at cycle 12.
    start = 1'b1; base_addr = 16'h0200;
    step();
    start = 1'b0;
    for (int i = 1; i < 12; i++) step();
    chk("mid_en_before", mem_enable, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_en", mem_enable, 0);
    chk("mid_vld", window_valid, 0);
    chk_win("mid_win", window_out, '0);
    step(); step();
    chk("mid_stay_idle", busy, 0);
    fetch("mid_refetch", 16'h0300);
    window_ready = 1'b0;
    step();

    // Back-to-back windows, ready tied high.
    window_ready = 1'b1; ndone = 0;
    fetch("b2b_a", 16'h0000);
    fetch("b2b_b", 16'h0019);
    chk("b2b_ndone", ndone, 2);
    a = 16'h0019 + 16'd24;
    chk("b2b_last_addr", mem_address, a);
    window_ready = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
